// File: rtl/seg_serial_tx_pkg.sv
// Shared types and defaults for the seven-segment serial transmitter.
package seg_tx_pkg;

  localparam int DATA_W_DEF = 64;  // eight segment bytes
  localparam int DIV_DEF    = 2;   // serial-clock half-period in clk cycles
  localparam int DIGITS     = 8;   // byte lanes in one frame

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

endpackage

// File: rtl/seg_serial_tx_if.sv
// Frame request and board-side pins of the segment transmitter.
interface seg_serial_tx_if
  import seg_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic [DATA_W-1:0] par_data;
  logic              busy;
  logic              done;
  logic              s_clk;
  logic              s_dat;
  logic              s_latch;
  logic              s_clrn;

  // upstream segment stage
  modport master (
    output start, par_data,
    input  busy, done, s_clk, s_dat, s_latch, s_clrn
  );

  // transmitter
  modport slave (
    input  start, par_data,
    output busy, done, s_clk, s_dat, s_latch, s_clrn
  );

endinterface

// File: rtl/seg_serial_tx_tick.sv
// Phase counter: one-cycle tick every DIV cycles while enabled.
module seg_tx_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(DIV) + 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // tick is the last cycle of the current phase
  assign tick = en && (cnt == LAST);

  // count within a phase; parked at zero while disabled so every frame
  // starts a fresh phase on the accepting edge
  always_ff @(posedge clk) begin
    if (rst || !en)  cnt <= '0;
    else if (tick)   cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_serial_tx.sv
// Shifts a 64-bit segment frame MSB-first into the daisy-chained 595s,
// then pulses the latch. One frame per accepted start.
module seg_serial_tx
  import seg_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV    = DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  seg_serial_tx_if.slave  bus
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_d;
  logic [DATA_W-1:0] sr, sr_d;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic              hi, hi_d;       // 1 while in the high half of a bit
  logic              done_d;
  logic              tick;

  seg_tx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // state, shift register, bit counter and phase flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      hi      <= 1'b0;
    end else begin
      state   <= state_d;
      sr      <= sr_d;
      bit_cnt <= bit_d;
      hi      <= hi_d;
    end
  end

  // next state: low half, high half, shift at the end of each high half
  always_comb begin
    state_d = state;
    sr_d    = sr;
    bit_d   = bit_cnt;
    hi_d    = hi;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sr_d    = bus.par_data;
          bit_d   = '0;
          hi_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!hi) begin
            hi_d = 1'b1;
          end else begin
            hi_d  = 1'b0;
            sr_d  = {sr[DATA_W-2:0], 1'b0};
            bit_d = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // pins are registered off the next-state values so they line up with state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.s_clk   <= 1'b0;
      bus.s_dat   <= 1'b0;
      bus.s_latch <= 1'b0;
    end else begin
      bus.busy    <= (state_d != IDLE);
      bus.done    <= done_d;
      bus.s_clk   <= (state_d == SHIFT) && hi_d;
      bus.s_dat   <= (state_d == SHIFT) && sr_d[DATA_W-1];
      bus.s_latch <= (state_d == LATCH);
    end
  end

  // external clear follows reset, one edge late
  always_ff @(posedge clk) begin
    bus.s_clrn <= ~rst;
  end

endmodule

// File: tb/tb_seg_serial_tx.sv
// Directed bench: DIV=2 and DIV=1 instances, shift-register model on s_clk.
module tb_seg_serial_tx;
  import seg_tx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, rst1;

  seg_serial_tx_if #(.DATA_W(64)) b2 ();
  seg_serial_tx_if #(.DATA_W(64)) b1 ();

  seg_serial_tx #(.DATA_W(64), .DIV(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));
  seg_serial_tx #(.DATA_W(64), .DIV(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // board-side models: 64-bit chain clocked on s_clk, latched on s_latch
  logic [63:0] mdl2 = '0, mdl1 = '0, lat2 = '0, lat1 = '0;
  int rises2 = 0, rises1 = 0, latches2 = 0, dones2 = 0, dones1 = 0;

  always @(posedge b2.s_clk) begin mdl2 = {mdl2[62:0], b2.s_dat}; rises2++; end
  always @(posedge b1.s_clk) begin mdl1 = {mdl1[62:0], b1.s_dat}; rises1++; end
  always @(posedge b2.s_latch) begin lat2 = mdl2; latches2++; end
  always @(posedge b1.s_latch) lat1 = mdl1;
  always @(posedge clk) if (b2.done === 1'b1) dones2++;
  always @(posedge clk) if (b1.done === 1'b1) dones1++;

  initial begin
    int n, fr, ln, r0, l0, d0;

    rst2 = 1'b1; rst1 = 1'b1;
    b2.start = 1'b0; b2.par_data = '0;
    b1.start = 1'b0; b1.par_data = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy",  b2.busy,    1'b0);
    chk("rst_done",  b2.done,    1'b0);
    chk("rst_sclk",  b2.s_clk,   1'b0);
    chk("rst_sdat",  b2.s_dat,   1'b0);
    chk("rst_latch", b2.s_latch, 1'b0);
    chk("rst_clrn",  b2.s_clrn,  1'b0);
    rst2 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("clrn_rel2", b2.s_clrn, 1'b1);
    chk("clrn_rel1", b1.s_clrn, 1'b1);

    // frame 1, DIV=2
    r0 = rises2; l0 = latches2; d0 = dones2;
    b2.par_data = 64'hFEDC_BA98_7654_3210; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    chk("e0_busy", b2.busy,  1'b1);
    chk("e0_sdat", b2.s_dat, 1'b1);
    chk("e0_sclk", b2.s_clk, 1'b0);
    n = 0; fr = -1; ln = -1;
    while (b2.done !== 1'b1 && n < 600) begin
      @(negedge clk); n++;
      if (b2.s_clk === 1'b1 && fr < 0) fr = n;
      if (b2.s_latch === 1'b1 && ln < 0) ln = n;
    end
    chk("f1_first_rise", fr, 2);
    chk("f1_latch_at",   ln, 256);
    chk("f1_done_at",    n,  258);
    chk("f1_busy_done",  b2.busy, 1'b0);
    chk("f1_latched",    lat2, 64'hFEDC_BA98_7654_3210);
    chk("f1_rises",      rises2 - r0, 64);
    chk("f1_latches",    latches2 - l0, 1);
    @(negedge clk);
    chk("f1_done_pulse", b2.done, 1'b0);
    chk("f1_done_cnt",   dones2 - d0, 1);

    // frame 2, DIV=1
    r0 = rises1;
    b1.par_data = 64'h8000_0000_0000_0001; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    chk("d1_e0_sdat", b1.s_dat, 1'b1);
    n = 0;
    while (b1.done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("d1_done_at", n, 129);
    chk("d1_latched", lat1, 64'h8000_0000_0000_0001);
    chk("d1_rises",   rises1 - r0, 64);
    @(negedge clk);
    chk("d1_done_cnt", dones1, 1);

    // start held high, data changed mid-frame
    b2.par_data = 64'h0123_4567_89AB_CDEF; b2.start = 1'b1;
    @(negedge clk);
    chk("bb_e0_sdat", b2.s_dat, 1'b0);
    n = 0;
    while (b2.done !== 1'b1 && n < 600) begin
      @(negedge clk); n++;
      if (n == 100) b2.par_data = 64'hFFFF_0000_AAAA_5555;
    end
    chk("bb_done_at",  n, 258);
    chk("bb_latched1", lat2, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    b2.start = 1'b0;
    chk("bb_busy2", b2.busy,  1'b1);
    chk("bb_sdat2", b2.s_dat, 1'b1);
    n = 0;
    while (b2.done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("bb_done2_at", n, 258);
    chk("bb_latched2", lat2, 64'hFFFF_0000_AAAA_5555);
    @(negedge clk);

    // reset mid-frame
    b2.par_data = 64'hFFFF_FFFF_FFFF_FFFF; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    repeat (50) @(negedge clk);
    l0 = latches2; d0 = dones2;
    rst2 = 1'b1;
    @(negedge clk);
    chk("ab_busy",  b2.busy,    1'b0);
    chk("ab_done",  b2.done,    1'b0);
    chk("ab_sclk",  b2.s_clk,   1'b0);
    chk("ab_sdat",  b2.s_dat,   1'b0);
    chk("ab_latch", b2.s_latch, 1'b0);
    chk("ab_clrn",  b2.s_clrn,  1'b0);
    @(negedge clk);
    rst2 = 1'b0;
    repeat (300) @(negedge clk);
    chk("ab_no_latch", latches2 - l0, 0);
    chk("ab_no_done",  dones2 - d0, 0);
    chk("ab_clrn_rel", b2.s_clrn, 1'b1);
    b2.par_data = 64'h0F1E_2D3C_4B5A_6978; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    n = 0;
    while (b2.done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    chk("ab_done_at", n, 258);
    chk("ab_latched", lat2, 64'h0F1E_2D3C_4B5A_6978);
    @(negedge clk);

    // start pulses during SHIFT and LATCH are ignored
    r0 = rises2; d0 = dones2;
    b2.par_data = 64'h3C3C_A5A5_0FF0_9669; b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    n = 0;
    while (b2.done !== 1'b1 && n < 600) begin
      @(negedge clk); n++;
      if (n == 30)  b2.start = 1'b1;
      if (n == 31)  b2.start = 1'b0;
      if (n == 256) begin
        chk("ig_in_latch", b2.s_latch, 1'b1);
        b2.start = 1'b1;
      end
      if (n == 257) b2.start = 1'b0;
    end
    chk("ig_done_at", n, 258);
    chk("ig_latched", lat2, 64'h3C3C_A5A5_0FF0_9669);
    repeat (300) @(negedge clk);
    chk("ig_done_cnt", dones2 - d0, 1);
    chk("ig_rises",    rises2 - r0, 64);
    chk("ig_idle",     b2.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
